// File: rtl/exec_defs_pkg.sv
// Shared definitions for the execute-stage sequencer.
// Class codes, trap causes, FSM states and ALU select values.
package exec_defs;

    localparam logic [3:0] CL_LUI    = 4'd0;
    localparam logic [3:0] CL_AUIPC  = 4'd1;
    localparam logic [3:0] CL_JAL    = 4'd2;
    localparam logic [3:0] CL_JALR   = 4'd3;
    localparam logic [3:0] CL_BRANCH = 4'd4;
    localparam logic [3:0] CL_LOAD   = 4'd5;
    localparam logic [3:0] CL_STORE  = 4'd6;
    localparam logic [3:0] CL_OPIMM  = 4'd7;
    localparam logic [3:0] CL_OP     = 4'd8;

    localparam logic [2:0] TC_ILLEGAL  = 3'd0;
    localparam logic [2:0] TC_IMISALGN = 3'd1;
    localparam logic [2:0] TC_LMISALGN = 3'd2;
    localparam logic [2:0] TC_SMISALGN = 3'd3;
    localparam logic [2:0] TC_BUSTMO   = 3'd4;

    localparam logic [2:0] ALU_LUI   = 3'd0;
    localparam logic [2:0] ALU_LINK  = 3'd1;
    localparam logic [2:0] ALU_OPIMM = 3'd5;
    localparam logic [2:0] ALU_OP    = 3'd6;

    localparam logic [1:0] ADDR_NONE = 2'd0;
    localparam logic [1:0] ADDR_PC   = 2'd1;
    localparam logic [1:0] ADDR_RS1  = 2'd2;
    localparam logic [1:0] ADDR_JALR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_RETIRE,
        S_TRAP
    } state_e;

    typedef struct packed {
        logic [3:0]  cls;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
    } instr_t;

endpackage

// File: rtl/alu_unit.sv
// Integer ALU plus address adder and branch comparator.
// fault flags funct7 encodings the base integer ISA does not define.
module alu_unit
    import exec_defs::*;
(
    input  logic [2:0]  alu_op,
    input  logic [1:0]  addr_alu_op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] addr_alu_out,
    output logic        cmp_out,
    output logic        fault
);

    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] pc_sum;
    logic [31:0] rs_sum;
    logic [4:0]  shamt;
    logic        sub;

    always_comb begin
        b      = (alu_op == ALU_OP) ? rs2 : imm;
        shamt  = b[4:0];
        sub    = (alu_op == ALU_OP) && funct7[5];
        pc_sum = pc + imm;
        rs_sum = rs1 + imm;
        res    = '0;
        case (funct3)
            3'b000: res = sub ? rs1 - b : rs1 + b;
            3'b001: res = rs1 << shamt;
            3'b010: res = {31'b0, $signed(rs1) < $signed(b)};
            3'b011: res = {31'b0, rs1 < b};
            3'b100: res = rs1 ^ b;
            3'b101: res = funct7[5] ? 32'($signed(rs1) >>> shamt)
                                    : rs1 >> shamt;
            3'b110: res = rs1 | b;
            default: res = rs1 & b;
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_LUI:   alu_out = imm;
            ALU_LINK:  alu_out = pc + 32'd4;
            ALU_OPIMM: alu_out = res;
            ALU_OP:    alu_out = res;
            default:   alu_out = '0;
        endcase
    end

    always_comb begin
        addr_alu_out = '0;
        case (addr_alu_op)
            ADDR_PC:   addr_alu_out = pc_sum;
            ADDR_RS1:  addr_alu_out = rs_sum;
            ADDR_JALR: addr_alu_out = {rs_sum[31:1], 1'b0};
            default:   addr_alu_out = '0;
        endcase
    end

    always_comb begin
        cmp_out = 1'b0;
        case (funct3)
            3'b000: cmp_out = rs1 == rs2;
            3'b001: cmp_out = rs1 != rs2;
            3'b100: cmp_out = $signed(rs1) < $signed(rs2);
            3'b101: cmp_out = $signed(rs1) >= $signed(rs2);
            3'b110: cmp_out = rs1 < rs2;
            3'b111: cmp_out = rs1 >= rs2;
            default: cmp_out = 1'b0;
        endcase
    end

    always_comb begin
        fault = 1'b0;
        if (alu_op == ALU_OPIMM) begin
            fault = (funct3 == 3'b001 && funct7 != 7'h00)
                 || (funct3 == 3'b101 && funct7 != 7'h00
                     && funct7 != 7'h20);
        end else if (alu_op == ALU_OP) begin
            fault = !(funct7 == 7'h00
                   || (funct7 == 7'h20
                       && (funct3 == 3'b000 || funct3 == 3'b101)));
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: runs one instruction at a time through
// the ALU or the data-memory port and emits a one-cycle retire.
module exec_ctrl
    import exec_defs::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [3:0]  dec_class,
    input  logic [2:0]  dec_funct3,
    input  logic [31:0] dec_imm,
    input  logic [31:0] dec_rs1,
    input  logic [31:0] dec_rs2,
    input  logic [31:0] dec_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ret_valid,
    output logic        ret_wb_en,
    output logic [31:0] ret_wb_data,
    output logic [31:0] ret_next_pc,
    output logic        ret_trap,
    output logic [2:0]  ret_cause
);

    state_e      state, state_n;
    instr_t      ins;
    logic [31:0] cnt;

    logic [2:0]  alu_op;
    logic [1:0]  addr_op;
    logic [31:0] alu_out, tgt;
    logic        cmp_out, fault;

    logic        wb, is_mem, is_load, illegal, jump, mis;
    logic [31:0] ex_data, ex_npc, pc4;
    logic [31:0] st_wdata, ld_data, shifted;
    logic [3:0]  st_wstrb;
    logic        tmo_hit, xfer;

    logic        trap_n, wb_en_n;
    logic [2:0]  cause_n;
    logic [31:0] wb_data_n, npc_n;

    alu_unit u_alu (
        .alu_op       (alu_op),
        .addr_alu_op  (addr_op),
        .funct3       (ins.funct3),
        .funct7       (ins.imm[11:5]),
        .rs1          (ins.rs1),
        .rs2          (ins.rs2),
        .imm          (ins.imm),
        .pc           (ins.pc),
        .alu_out      (alu_out),
        .addr_alu_out (tgt),
        .cmp_out      (cmp_out),
        .fault        (fault)
    );

    assign pc4  = ins.pc + 32'd4;
    assign xfer = (state == S_IDLE) && dec_valid && dec_ready;
    assign tmo_hit = (MEM_TIMEOUT != 0)
                  && (cnt == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        alu_op  = ALU_LUI;
        addr_op = ADDR_NONE;
        wb      = 1'b0;
        is_mem  = 1'b0;
        is_load = 1'b0;
        illegal = 1'b0;
        jump    = 1'b0;
        mis     = 1'b0;
        ex_data = alu_out;
        case (ins.cls)
            CL_LUI: wb = 1'b1;
            CL_AUIPC: begin
                addr_op = ADDR_PC;
                wb      = 1'b1;
                ex_data = tgt;
            end
            CL_JAL: begin
                alu_op  = ALU_LINK;
                addr_op = ADDR_PC;
                wb      = 1'b1;
                jump    = 1'b1;
            end
            CL_JALR: begin
                alu_op  = ALU_LINK;
                addr_op = ADDR_JALR;
                wb      = 1'b1;
                jump    = 1'b1;
            end
            CL_BRANCH: begin
                addr_op = ADDR_PC;
                jump    = cmp_out;
                illegal = ins.funct3[2:1] == 2'b01;
            end
            CL_LOAD: begin
                addr_op = ADDR_RS1;
                wb      = 1'b1;
                is_mem  = 1'b1;
                is_load = 1'b1;
                illegal = ins.funct3 == 3'b011 || ins.funct3[2:1] == 2'b11;
            end
            CL_STORE: begin
                addr_op = ADDR_RS1;
                is_mem  = 1'b1;
                illegal = ins.funct3 >= 3'b011;
            end
            CL_OPIMM: begin
                alu_op  = ALU_OPIMM;
                wb      = 1'b1;
                illegal = fault;
            end
            CL_OP: begin
                alu_op  = ALU_OP;
                wb      = 1'b1;
                illegal = fault;
            end
            default: illegal = 1'b1;
        endcase
        // funct3[1:0] gives access size for both loads and stores
        if (is_mem) begin
            mis = (ins.funct3[1:0] == 2'b01 && tgt[0])
               || (ins.funct3[1:0] == 2'b10 && tgt[1:0] != 2'b00);
        end
        ex_npc = jump ? tgt : pc4;
    end

    always_comb begin
        st_wdata = ins.rs2;
        st_wstrb = 4'b1111;
        case (ins.funct3[1:0])
            2'b00: begin
                st_wdata = {4{ins.rs2[7:0]}};
                st_wstrb = 4'b0001 << tgt[1:0];
            end
            2'b01: begin
                st_wdata = {2{ins.rs2[15:0]}};
                st_wstrb = tgt[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = ins.rs2;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {tgt[1:0], 3'b000};
        ld_data = shifted;
        case (ins.funct3)
            3'b000: ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001: ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100: ld_data = {24'b0, shifted[7:0]};
            3'b101: ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        state_n   = state;
        trap_n    = 1'b0;
        cause_n   = TC_ILLEGAL;
        wb_en_n   = 1'b0;
        wb_data_n = '0;
        npc_n     = '0;
        case (state)
            S_IDLE: if (xfer) state_n = S_EXEC;
            S_EXEC: begin
                if (illegal || (jump && tgt[1]) || mis) begin
                    state_n = S_TRAP;
                    trap_n  = 1'b1;
                    npc_n   = ins.pc;
                    if (illegal)
                        cause_n = TC_ILLEGAL;
                    else if (jump && tgt[1])
                        cause_n = TC_IMISALGN;
                    else
                        cause_n = is_load ? TC_LMISALGN : TC_SMISALGN;
                end else if (is_mem) begin
                    state_n = S_MEM_REQ;
                end else begin
                    state_n   = S_RETIRE;
                    wb_en_n   = wb;
                    wb_data_n = ex_data;
                    npc_n     = ex_npc;
                end
            end
            S_MEM_REQ, S_MEM_WAIT: begin
                if (state == S_MEM_REQ && mem_gnt) begin
                    state_n = S_MEM_WAIT;
                end else if (state == S_MEM_WAIT && mem_rvalid) begin
                    state_n   = S_RETIRE;
                    wb_en_n   = is_load;
                    wb_data_n = is_load ? ld_data : '0;
                    npc_n     = pc4;
                end else if (tmo_hit) begin
                    state_n = S_TRAP;
                    trap_n  = 1'b1;
                    cause_n = TC_BUSTMO;
                    npc_n   = ins.pc;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ins         <= '0;
            cnt         <= '0;
            dec_ready   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            ret_valid   <= 1'b0;
            ret_wb_en   <= 1'b0;
            ret_wb_data <= '0;
            ret_next_pc <= '0;
            ret_trap    <= 1'b0;
            ret_cause   <= '0;
        end else begin
            state       <= state_n;
            dec_ready   <= state_n == S_IDLE;
            mem_req     <= state_n == S_MEM_REQ;
            ret_valid   <= state_n == S_RETIRE || state_n == S_TRAP;
            ret_trap    <= trap_n;
            ret_cause   <= cause_n;
            ret_wb_en   <= wb_en_n;
            ret_wb_data <= wb_data_n;
            ret_next_pc <= npc_n;
            if (xfer) begin
                ins <= '{cls: dec_class, funct3: dec_funct3,
                         imm: dec_imm, rs1: dec_rs1,
                         rs2: dec_rs2, pc: dec_pc};
            end
            if (state == S_EXEC || (state == S_MEM_REQ && mem_gnt))
                cnt <= '0;
            else if (state == S_MEM_REQ || state == S_MEM_WAIT)
                cnt <= cnt + 32'd1;
            // request fields are frozen from EXEC until the grant
            if (state == S_EXEC && state_n == S_MEM_REQ) begin
                mem_we    <= ins.cls == CL_STORE;
                mem_addr  <= {tgt[31:2], 2'b00};
                mem_wdata <= ins.cls == CL_STORE ? st_wdata : '0;
                mem_wstrb <= ins.cls == CL_STORE ? st_wstrb : 4'b0000;
            end else if (state_n != S_MEM_REQ) begin
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: ALU, branch, load/store, traps,
// bus timeout and mid-transaction reset.
module tb_exec_ctrl;

    localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2;
    localparam logic [3:0] C_BR = 4'd4, C_LD = 4'd5, C_ST = 4'd6;
    localparam logic [3:0] C_OPI = 4'd7, C_OP = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [3:0]  dec_class = '0;
    logic [2:0]  dec_funct3 = '0;
    logic [31:0] dec_imm = '0, dec_rs1 = '0, dec_rs2 = '0, dec_pc = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ret_valid, ret_wb_en, ret_trap;
    logic [31:0] ret_wb_data, ret_next_pc;
    logic [2:0]  ret_cause;

    int total = 0;
    int bad = 0;
    int n, reqs, seen;

    always #5 clk = ~clk;

    exec_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_class(dec_class), .dec_funct3(dec_funct3),
        .dec_imm(dec_imm), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_pc(dec_pc),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ret_valid(ret_valid), .ret_wb_en(ret_wb_en),
        .ret_wb_data(ret_wb_data), .ret_next_pc(ret_next_pc),
        .ret_trap(ret_trap), .ret_cause(ret_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] c, input logic [2:0] f3,
                        input logic [31:0] imm, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] pc);
        @(negedge clk);
        chk("ready_before_send", {31'b0, dec_ready}, 32'd1);
        dec_class  = c;
        dec_funct3 = f3;
        dec_imm    = imm;
        dec_rs1    = r1;
        dec_rs2    = r2;
        dec_pc     = pc;
        dec_valid  = 1'b1;
        @(posedge clk);
        #1 dec_valid = 1'b0;
    endtask

    task automatic wait_ret(output int cyc, output int rq);
        cyc = 0;
        rq  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_req) rq++;
        end while (!ret_valid && cyc < 20);
    endtask

    task automatic pulse_gnt();
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
    endtask

    task automatic pulse_rvalid(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dec_ready", {31'b0, dec_ready}, 32'd0);
        chk("rst_ret_valid", {31'b0, ret_valid}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_next_pc", ret_next_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rst", {31'b0, dec_ready}, 32'd1);

        // ADDI 5 + -3
        send(C_OPI, 3'b000, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'h10);
        wait_ret(n, reqs);
        chk("addi_lat", n, 32'd2);
        chk("addi_wb", ret_wb_data, 32'd2);
        chk("addi_npc", ret_next_pc, 32'h14);
        chk("addi_wben", {31'b0, ret_wb_en}, 32'd1);
        chk("addi_trap", {31'b0, ret_trap}, 32'd0);
        @(negedge clk);
        chk("addi_pulse", {31'b0, ret_valid}, 32'd0);

        send(C_LUI, 3'b000, 32'h1234_5000, 32'd0, 32'd0, 32'h20);
        wait_ret(n, reqs);
        chk("lui_wb", ret_wb_data, 32'h1234_5000);

        send(C_AUIPC, 3'b000, 32'h2000, 32'd0, 32'd0, 32'h1000);
        wait_ret(n, reqs);
        chk("auipc_wb", ret_wb_data, 32'h3000);

        send(C_JAL, 3'b000, 32'h40, 32'd0, 32'd0, 32'h200);
        wait_ret(n, reqs);
        chk("jal_npc", ret_next_pc, 32'h240);
        chk("jal_wb", ret_wb_data, 32'h204);

        // SUB: funct7 0x20 lives in imm[11:5]
        send(C_OP, 3'b000, 32'h400, 32'd10, 32'd3, 32'h30);
        wait_ret(n, reqs);
        chk("sub_wb", ret_wb_data, 32'd7);

        send(C_BR, 3'b000, 32'h20, 32'd7, 32'd7, 32'h100);
        wait_ret(n, reqs);
        chk("beq_npc", ret_next_pc, 32'h120);
        chk("beq_wben", {31'b0, ret_wb_en}, 32'd0);
        chk("beq_trap", {31'b0, ret_trap}, 32'd0);

        send(C_BR, 3'b001, 32'h20, 32'd7, 32'd7, 32'h100);
        wait_ret(n, reqs);
        chk("bne_npc", ret_next_pc, 32'h104);

        send(C_BR, 3'b000, 32'h22, 32'd7, 32'd7, 32'h100);
        wait_ret(n, reqs);
        chk("beq_mis_trap", {31'b0, ret_trap}, 32'd1);
        chk("beq_mis_cause", {29'b0, ret_cause}, 32'd1);
        chk("beq_mis_npc", ret_next_pc, 32'h100);
        chk("beq_mis_wben", {31'b0, ret_wb_en}, 32'd0);

        send(C_OP, 3'b000, 32'h20, 32'd3, 32'd4, 32'h40);
        wait_ret(n, reqs);
        chk("op_f7_trap", {31'b0, ret_trap}, 32'd1);
        chk("op_f7_cause", {29'b0, ret_cause}, 32'd0);

        send(4'd12, 3'b000, 32'h0, 32'd0, 32'd0, 32'h50);
        wait_ret(n, reqs);
        chk("cls12_lat", n, 32'd2);
        chk("cls12_trap", {31'b0, ret_trap}, 32'd1);
        chk("cls12_cause", {29'b0, ret_cause}, 32'd0);

        // LH at 0x1002, grant after three waiting cycles
        send(C_LD, 3'b001, 32'd2, 32'h1000, 32'd0, 32'h400);
        @(negedge clk);
        chk("lh_exec_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk("lh_req", {31'b0, mem_req}, 32'd1);
        chk("lh_addr", mem_addr, 32'h1000);
        chk("lh_we", {31'b0, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        chk("lh_req_hold", {31'b0, mem_req}, 32'd1);
        chk("lh_addr_hold", mem_addr, 32'h1000);
        @(negedge clk);
        pulse_gnt();
        @(negedge clk);
        chk("lh_req_drop", {31'b0, mem_req}, 32'd0);
        pulse_rvalid(32'h8001_1234);
        @(negedge clk);
        chk("lh_ret", {31'b0, ret_valid}, 32'd1);
        chk("lh_wb", ret_wb_data, 32'hFFFF_8001);
        chk("lh_wben", {31'b0, ret_wb_en}, 32'd1);
        chk("lh_npc", ret_next_pc, 32'h404);
        chk("lh_trap", {31'b0, ret_trap}, 32'd0);

        send(C_LD, 3'b001, 32'd1, 32'h1000, 32'd0, 32'h600);
        wait_ret(n, reqs);
        chk("lh_mis_lat", n, 32'd2);
        chk("lh_mis_noreq", reqs, 32'd0);
        chk("lh_mis_cause", {29'b0, ret_cause}, 32'd2);
        chk("lh_mis_trap", {31'b0, ret_trap}, 32'd1);
        chk("lh_mis_npc", ret_next_pc, 32'h600);

        // SB at 0x2003
        send(C_ST, 3'b000, 32'd3, 32'h2000, 32'hAB, 32'h500);
        @(negedge clk);
        @(negedge clk);
        chk("sb_req", {31'b0, mem_req}, 32'd1);
        chk("sb_addr", mem_addr, 32'h2000);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_strb", {28'b0, mem_wstrb}, 32'h8);
        chk("sb_we", {31'b0, mem_we}, 32'd1);
        pulse_gnt();
        @(negedge clk);
        pulse_rvalid(32'h0);
        @(negedge clk);
        chk("sb_ret", {31'b0, ret_valid}, 32'd1);
        chk("sb_wben", {31'b0, ret_wb_en}, 32'd0);
        chk("sb_npc", ret_next_pc, 32'h504);

        // LW with no grant: four request cycles then timeout trap
        send(C_LD, 3'b010, 32'd4, 32'h3000, 32'd0, 32'h700);
        wait_ret(n, reqs);
        chk("tmo_lat", n, 32'd6);
        chk("tmo_reqs", reqs, 32'd4);
        chk("tmo_trap", {31'b0, ret_trap}, 32'd1);
        chk("tmo_cause", {29'b0, ret_cause}, 32'd4);
        chk("tmo_npc", ret_next_pc, 32'h700);
        chk("tmo_req_drop", {31'b0, mem_req}, 32'd0);

        // reset while the request is outstanding
        send(C_LD, 3'b010, 32'd0, 32'h3000, 32'd0, 32'h800);
        @(negedge clk);
        @(negedge clk);
        chk("rreq_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1 chk("rreq_req_clr", {31'b0, mem_req}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rreq_ready", {31'b0, dec_ready}, 32'd1);

        // reset while waiting for the response
        send(C_LD, 3'b010, 32'd0, 32'h3000, 32'd0, 32'h900);
        @(negedge clk);
        @(negedge clk);
        pulse_gnt();
        @(negedge clk);
        chk("rwait_state", {31'b0, mem_req}, 32'd0);
        rst_n = 1'b0;
        #1 chk("rwait_req", {31'b0, mem_req}, 32'd0);
        chk("rwait_ready", {31'b0, dec_ready}, 32'd0);
        #1 rst_n = 1'b1;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        chk("rwait_ready_next", {31'b0, dec_ready}, 32'd1);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ret_valid) seen++;
        end
        chk("rwait_no_ret", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execute-stage sequencer for the core. Accepts one decoded instruction at a time from decode, drives a single `alu_unit` instance with the right operation selects, and runs multi-cycle load/store transactions on the data-memory port. Results go back as a one-cycle retire pulse carrying write-back data, next PC and trap status. It sits between decode and the register-file/PC update logic.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: cycles waiting for `mem_gnt` or `mem_rvalid` before a bus-fault trap; 0 disables the timeout.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decoded instruction valid.
- `dec_ready`  out  1  sequencer can accept; a transfer occurs when valid && ready.
- `dec_class`  in  4  instruction class: LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OPIMM=7, OP=8; 9–15 illegal.
- `dec_funct3`  in  3  funct3 field.
- `dec_imm`  in  32  sign-extended immediate. Bits [11:5] carry funct7 for OP/OPIMM shifts.
- `dec_rs1`, `dec_rs2`, `dec_pc`  in  32 each  operand and PC values.
- `mem_req`  out  1  memory request; held until `mem_gnt`.
- `mem_we`  out  1  store when 1.
- `mem_addr`  out  32  word-aligned address ([1:0]=0).
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_wstrb`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  load data valid, or store completion.
- `mem_rdata`  in  32  load data.
- `ret_valid`  out  1  one-cycle retire pulse.
- `ret_wb_en`  out  1  write `ret_wb_data` to rd.
- `ret_wb_data`  out  32  write-back value.
- `ret_next_pc`  out  32  next PC.
- `ret_trap`  out  1  instruction trapped; `ret_wb_en`=0.
- `ret_cause`  out  3  0 illegal, 1 instr-misaligned, 2 load-misaligned, 3 store-misaligned, 4 bus-timeout.

## Operation
FSM states:
- IDLE: `dec_ready`=1. On transfer, latch all `dec_*` inputs and go to EXEC.
- EXEC: drive the ALU from the latched fields.
  - alu_op: LUI→0, JAL/JALR→1, OPIMM→5, OP→6.
  - addr_alu_op: AUIPC/JAL/BRANCH→1, LOAD/STORE→2, JALR→3.
  - Result select: AUIPC writes `addr_alu_out`; others write `alu_out`.
  - BRANCH: taken = `cmp_out`. funct3 010/011 → illegal.
  - Next PC: JAL/JALR/taken branch → `addr_alu_out`; otherwise pc+4.
  - Illegal class or ALU `fault` → TRAP cause 0. Target with bit1 set → TRAP cause 1.
  - LOAD/STORE → MEM_REQ; everything else → RETIRE.
- MEM_REQ: `mem_req`=1, address = `addr_alu_out` with [1:0] cleared; hold until `mem_gnt`, then MEM_WAIT.
  - Misalignment is checked in EXEC. Halfword requires addr[0]=0; word requires addr[1:0]=0. Misaligned → TRAP cause 2 (load) or 3 (store), and no request is issued.
  - Illegal funct3 (load 011/110/111, store ≥011) → TRAP cause 0.
- MEM_WAIT: on `mem_rvalid` go to RETIRE.
  - Load data: extract the byte/halfword at addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores: `ret_wb_en`=0.
- RETIRE: drive `ret_valid`=1 for exactly one cycle, then IDLE.
- TRAP: drive `ret_valid`=1, `ret_trap`=1, `ret_next_pc` = latched pc, for one cycle; then IDLE.

Write-enable rule: `ret_wb_en` is 1 for LUI, AUIPC, JAL, JALR, LOAD, OP, OPIMM.

Store lane placement: SB replicates the byte into all lanes, strb = 1<<addr[1:0]. SH replicates the halfword, strb = 0011 or 1100. SW uses strb = 1111.

Timeout: a counter runs in MEM_REQ/MEM_WAIT. When it reaches MEM_TIMEOUT → TRAP cause 4, with `mem_req` dropped.

## Timing
- Reset values: state IDLE. All outputs are 0, including `dec_ready`, which goes to 1 on the first clock after deassertion.
- ALU instructions: accepted on edge N; `ret_valid` is high during cycle N+2.
- Memory instructions: latency is 3 cycles + grant wait + response wait. `mem_gnt` and `mem_rvalid` in the same cycle is illegal; the bench must not generate it.
- `dec_ready` is low from the cycle after acceptance until the return to IDLE, so there is no overlap between instructions.
- Registered outputs: `ret_*`, `mem_*`. All are held stable while `mem_req`=1 and not granted.
- `mem_rvalid`/`mem_gnt` outside MEM_REQ/MEM_WAIT are ignored.
- Reset asserted mid-transaction clears `mem_req` asynchronously and discards the instruction; no retire is produced.

## Structure
- Shared package/include `exec_defs`: class codes, trap causes, FSM state encoding, alu_op/addr_alu_op constants.
- One sub-module `alu_unit`, instantiated as is.
- Load extract and store lane logic stay inline.

## Test plan
- OPIMM ADDI rs1=5, imm=-3 → ret_valid at N+2, wb_data=2, next_pc=pc+4, wb_en=1.
- BEQ rs1=rs2=7, pc=0x100, imm=0x20 → next_pc=0x120, wb_en=0. Same with imm=0x22 → trap cause 1.
- LH addr=0x1002, mem_rdata=0x8001_xxxx, gnt delayed 3 cycles → wb_data=0xFFFF8001. LH at addr 0x1001 → cause 2, mem_req never asserted.
- SB addr=0x2003, rs2=0xAB → mem_wdata=0xABABABAB, strb=1000, we=1; retire with wb_en=0.
- OP with funct7=0x01 → trap cause 0. Class 12 → trap cause 0.
- LW with no gnt, MEM_TIMEOUT=4 → cause 4 after timeout. rst_n pulsed mid-MEM_WAIT → mem_req=0 immediately, no ret_valid, dec_ready=1 next cycle.
